// File: rtl/wb_pkg.sv
// Shared types and helpers for the memory-access / write-back stage.
package wb_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_e;

    function automatic int unsigned size_bytes(input mem_size_e size);
        case (size)
            BYTE:    return 1;
            HALF:    return 2;
            WORD:    return 4;
            default: return 8;
        endcase
    endfunction

    // A doubleword access on a 32-bit machine has no legal alignment at all.
    function automatic logic is_misaligned(input logic [2:0] off, input mem_size_e size,
                                           input int unsigned xlen);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return off[0];
            WORD:    return |off[1:0];
            default: return (xlen < 64) || (|off);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Byte-lane steering: extracts and extends load data, and positions store data/byte enables.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] addr_lo_i,
    input  mem_size_e                 size_i,
    input  logic                      sext_i,
    input  logic [XLEN-1:0]           rdata_i,
    input  logic [XLEN-1:0]           st_data_i,
    output logic [XLEN-1:0]           ld_data_o,
    output logic [XLEN-1:0]           st_wdata_o,
    output logic [XLEN/8-1:0]         st_be_o
);

    localparam int unsigned BYTES = XLEN / 8;

    int unsigned       nbytes;
    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   lane;
    logic [BYTES-1:0]  be_mask;
    logic              negative;

    always_comb begin
        nbytes = size_bytes(size_i);
        if (nbytes > BYTES) nbytes = BYTES;
        mask     = (nbytes == BYTES) ? '1 : ((XLEN'(1) << (8 * nbytes)) - XLEN'(1));
        be_mask  = (nbytes == BYTES) ? '1 : ((BYTES'(1) << nbytes) - BYTES'(1));
        lane     = rdata_i >> {addr_lo_i, 3'b000};
        // Top bit of the access width is the one bit set in mask but not in mask>>1.
        negative = |(lane & (mask ^ (mask >> 1)));
        ld_data_o  = (lane & mask) | ((sext_i && negative) ? ~mask : '0);
        st_wdata_o = (st_data_i & mask) << {addr_lo_i, 3'b000};
        st_be_o    = be_mask << addr_lo_i;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: one instruction in flight, load/store over req/gnt/rvalid.
module mem_wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [XLEN-1:0]   in_alu_res,
    input  logic              in_jmp,
    input  logic [XLEN-1:0]   in_jmp_pc,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_sext,
    input  logic [XLEN-1:0]   in_st_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              pc_we,
    output logic [XLEN-1:0]   pc_next,
    output logic              misalign
);

    localparam int OFFW = $clog2(XLEN / 8);

    state_e            state_q, state_d;
    logic [REG_AW-1:0] rd_q;
    logic              rd_we_q, jmp_q, mem_rd_q, mem_wr_q, sext_q;
    logic [XLEN-1:0]   alu_q, jmp_pc_q, st_data_q;
    mem_size_e         size_q;

    logic              rf_we_q, rf_we_d, pc_we_q, pc_we_d, misalign_q, misalign_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d, pc_next_q, pc_next_d;

    logic              accept, mem_op, misal_in, load_done, store_done;
    logic [XLEN-1:0]   ld_data, st_wdata;
    logic [XLEN/8-1:0] st_be;

    assign accept     = in_valid && (state_q == IDLE);
    assign mem_op     = in_mem_rd || in_mem_wr;
    assign misal_in   = mem_op && is_misaligned(in_alu_res[2:0], mem_size_e'(in_mem_size), XLEN);
    assign store_done = (state_q == REQ) && mem_gnt && mem_wr_q;
    assign load_done  = ((state_q == REQ) && mem_gnt && mem_rd_q && mem_rvalid)
                     || ((state_q == WAIT) && mem_rvalid);

    load_align #(.XLEN(XLEN)) u_align (
        .addr_lo_i  (alu_q[OFFW-1:0]),
        .size_i     (size_q),
        .sext_i     (sext_q),
        .rdata_i    (mem_rdata),
        .st_data_i  (st_data_q),
        .ld_data_o  (ld_data),
        .st_wdata_o (st_wdata),
        .st_be_o    (st_be)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d    = state_q;
        rf_we_d    = 1'b0;
        pc_we_d    = 1'b0;
        misalign_d = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pc_next_d  = pc_next_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mem_op && !misal_in) begin
                        state_d = REQ;
                    end else begin
                        state_d    = WB;
                        rf_we_d    = in_rd_we && (in_rd != '0) && !misal_in;
                        rf_waddr_d = in_rd;
                        rf_wdata_d = in_alu_res;
                        pc_we_d    = in_jmp;
                        pc_next_d  = in_jmp_pc;
                        misalign_d = misal_in;
                    end
                end
            end
            REQ:     if (mem_gnt && mem_rd_q && !mem_rvalid) state_d = WAIT;
            WB:      state_d = IDLE;
            default: ;
        endcase

        if (store_done || load_done) begin
            state_d    = WB;
            rf_we_d    = load_done && rd_we_q && (rd_q != '0);
            rf_waddr_d = rd_q;
            rf_wdata_d = load_done ? ld_data : rf_wdata_q;
            pc_we_d    = jmp_q;
            pc_next_d  = jmp_pc_q;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            rd_we_q    <= 1'b0;
            alu_q      <= '0;
            jmp_q      <= 1'b0;
            jmp_pc_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            size_q     <= BYTE;
            sext_q     <= 1'b0;
            st_data_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pc_we_q    <= 1'b0;
            pc_next_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pc_we_q    <= pc_we_d;
            pc_next_q  <= pc_next_d;
            misalign_q <= misalign_d;
            if (accept) begin
                rd_q      <= in_rd;
                rd_we_q   <= in_rd_we;
                alu_q     <= in_alu_res;
                jmp_q     <= in_jmp;
                jmp_pc_q  <= in_jmp_pc;
                mem_rd_q  <= in_mem_rd;
                mem_wr_q  <= in_mem_wr;
                size_q    <= mem_size_e'(in_mem_size);
                sext_q    <= in_mem_sext;
                st_data_q <= in_st_data;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && mem_wr_q;
    assign mem_addr  = {alu_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign mem_wdata = mem_we ? st_wdata : '0;
    assign mem_be    = mem_req ? st_be : '0;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign pc_we     = pc_we_q;
    assign pc_next   = pc_next_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised scoreboard bench for mem_wb_stage (XLEN=32): driver pushes expectations, monitor compares.
module tb_mem_wb_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid, in_ready, in_rd_we, in_jmp, in_mem_rd, in_mem_wr, in_mem_sext;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_alu_res, in_jmp_pc, in_st_data;
    logic [1:0]        in_mem_size;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
    logic [3:0]        mem_be;
    logic              rf_we, pc_we, misalign;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata, pc_next;

    mem_wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_alu_res(in_alu_res), .in_jmp(in_jmp), .in_jmp_pc(in_jmp_pc),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_mem_size(in_mem_size),
        .in_mem_sext(in_mem_sext), .in_st_data(in_st_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc_we(pc_we), .pc_next(pc_next), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cycle;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        pc_we;
        logic [31:0] pc;
        logic        mis;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_exp_t;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];
    logic     req_expected = 1'b0;
    int       n_vec = 0;
    int       n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample away from the rising edge and pop expectations as outputs appear.
    initial begin
        wb_exp_t  we_e;
        mem_exp_t me_e;
        forever begin
            @(negedge clk);
            check("mem_req", mem_req, req_expected);
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL mem_unexpected: request addr 0x%0h with none expected", mem_addr);
                end else begin
                    me_e = mem_q[0];
                    check("mem_we", mem_we, me_e.we);
                    check("mem_addr", mem_addr, me_e.addr);
                    check("mem_be", mem_be, me_e.be);
                    if (me_e.we) check("mem_wdata", mem_wdata, me_e.wdata);
                    if (mem_gnt) void'(mem_q.pop_front());
                end
            end
            if (rf_we || pc_we || misalign) begin
                if (wb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wb_unexpected: rf_we=%0b pc_we=%0b misalign=%0b with none expected",
                             rf_we, pc_we, misalign);
                end else begin
                    we_e = wb_q.pop_front();
                    check("wb_cycle", cyc, we_e.cycle);
                    check("rf_we", rf_we, we_e.rf_we);
                    if (we_e.rf_we) begin
                        check("rf_waddr", rf_waddr, we_e.waddr);
                        check("rf_wdata", rf_wdata, we_e.wdata);
                    end
                    check("pc_we", pc_we, we_e.pc_we);
                    if (we_e.pc_we) check("pc_next", pc_next, we_e.pc);
                    check("misalign", misalign, we_e.mis);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // op: 0 ALU, 1 load, 2 store. dg/dr: cycles before gnt / extra cycles before rvalid.
    task automatic run_txn(input int op, input logic [4:0] rd, input logic rd_we,
                           input logic [31:0] addr, input logic jmp, input logic [31:0] jpc,
                           input logic [1:0] size, input logic sext, input logic [31:0] st,
                           input logic [31:0] rdata, input int dg, input int dr, input logic abort);
        int       off, nb, lim, waited;
        longint   span, lane, sw;
        logic     is_mem, mis;
        wb_exp_t  w;
        mem_exp_t m;

        off    = int'(addr % 4);
        nb     = 1 << size;
        lim    = (nb > 4) ? 4 : nb;
        is_mem = (op != 0);
        mis    = is_mem && ((nb > 4) || (off % nb) != 0);
        span   = longint'(1) << (8 * lim);
        lane   = (longint'(rdata) >> (8 * off)) % span;
        if (sext && lane >= span / 2) lane = lane - span;
        sw     = (longint'(st) % span) << (8 * off);

        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("in_ready_idle", in_ready, 1'b1);

        in_valid    = 1'b1;
        in_rd       = rd;
        in_rd_we    = rd_we;
        in_alu_res  = addr;
        in_jmp      = jmp;
        in_jmp_pc   = jpc;
        in_mem_rd   = (op == 1);
        in_mem_wr   = (op == 2);
        in_mem_size = size;
        in_mem_sext = sext;
        in_st_data  = st;
        if (is_mem && !mis) begin
            m.we    = (op == 2);
            m.addr  = addr & 32'hFFFF_FFFC;
            m.wdata = sw[31:0];
            m.be    = 4'(((1 << lim) - 1) << off);
            mem_q.push_back(m);
        end
        tick();
        in_valid   = 1'b0;
        in_mem_rd  = 1'b0;
        in_mem_wr  = 1'b0;
        in_rd      = 5'($urandom);
        in_alu_res = $urandom;
        in_jmp_pc  = $urandom;
        in_st_data = $urandom;

        w.waddr = rd;
        w.pc_we = jmp;
        w.pc    = jpc;
        if (!is_mem || mis) begin
            w.rf_we = !mis && rd_we && (rd != 0);
            w.wdata = addr;
            w.mis   = mis;
        end else begin
            req_expected = 1'b1;
            repeat (dg) tick();
            mem_gnt   = 1'b1;
            mem_rdata = $urandom;
            if (op == 1 && dr == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            tick();
            mem_gnt      = 1'b0;
            mem_rvalid   = 1'b0;
            mem_rdata    = $urandom;
            req_expected = 1'b0;
            if (op == 1 && dr > 0) begin
                repeat (dr - 1) tick();
                if (abort) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_mem_req", mem_req, 1'b0);
                    check("rst_in_ready", in_ready, 1'b1);
                    tick();
                    rst_n = 1'b1;
                    repeat (4) tick();
                    check("rst_idle_ready", in_ready, 1'b1);
                    return;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                tick();
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            w.rf_we = (op == 1) && rd_we && (rd != 0);
            w.wdata = lane[31:0];
            w.mis   = 1'b0;
        end
        w.cycle = cyc;
        if (w.rf_we || w.pc_we || w.mis) wb_q.push_back(w);
        check("in_ready_wb", in_ready, 1'b0);
        tick();
        check("wb_pending", wb_q.size(), 0);
        check("in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] addr;
        logic [1:0]  size;
        logic [4:0]  rd;
        in_valid = 1'b0; in_rd = '0; in_rd_we = 1'b0; in_alu_res = '0; in_jmp = 1'b0;
        in_jmp_pc = '0; in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_mem_size = '0;
        in_mem_sext = 1'b0; in_st_data = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_pc_we", pc_we, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rf_waddr", rf_waddr, 5'h0);
        check("rst_rf_wdata", rf_wdata, 32'h0);
        check("rst_pc_next", pc_next, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_release", in_ready, 1'b1);

        run_txn(0, 5'd5, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn(0, 5'd0, 1'b1, 32'h0000_5678, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn(1, 5'd7, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 32'h80AA_BBCC, 1, 2, 1'b0);
        run_txn(1, 5'd8, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0);
        run_txn(2, 5'd3, 1'b1, 32'h0000_0102, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 3, 0, 1'b0);
        run_txn(1, 5'd4, 1'b1, 32'h0000_0101, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
        run_txn(1, 5'd9, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0400, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
        run_txn(1, 5'd10, 1'b1, 32'h0000_0206, 1'b0, 32'h0, 2'd1, 1'b1, 32'h0, 32'h9ABC_1234, 2, 3, 1'b0);
        run_txn(2, 5'd11, 1'b0, 32'h0000_0204, 1'b1, 32'h0000_0800, 2'd3, 1'b0, 32'h1, 32'h0, 0, 0, 1'b0);
        run_txn(1, 5'd6, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 0, 3, 1'b1);
        run_txn(0, 5'd12, 1'b1, 32'hDEAD_0000, 1'b1, 32'h0000_0040, 2'd0, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            addr = $urandom;
            size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'(1) << size) - 32'(1));
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run_txn($urandom_range(0, 2), rd, 1'($urandom_range(0, 1)), addr,
                    ($urandom_range(0, 3) == 0), $urandom, size, 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        repeat (3) tick();
        check("wb_queue_empty", wb_q.size(), 0);
        check("mem_queue_empty", mem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
